mc_control_fsm: RTL

Multi-cycle sequencer for the MIPS datapath: it sequences fetch, register read/decode, ALU, memory and register write-back over successive cycles, driving every datapath strobe and mux select. It sits beside the decode stage, takes instruction bits [31:26] from the instruction register, and replaces the single-cycle control decoder when the core runs in multi-cycle mode. It also handles the memory ready handshake and counts retired instructions.

---
 rtl/mc_control_fsm_if.sv | 37 +++
 rtl/mc_control_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer, slave = datapath/memory side.
interface mc_control_fsm_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal_op;
    logic        retire;
    logic [31:0] instr_count;
    logic [3:0]  state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, retire, instr_count, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, retire, instr_count, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/write-back
// strobes, mem_ready handshake and retired-instruction counter.
module mc_control_fsm (
    input logic              clk,
    input logic              reset,
    mc_control_fsm_if.master bus
);
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       retire;
    } ctrl_t;

    state_e      state_q, state_d;
    ctrl_t       ctrl, ctrl_out;
    logic [31:0] instr_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StFetch;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl.retire) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = StFetch;
        unique case (state_q)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                state_d        = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                ctrl.alu_src_b = 2'b11;
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        // Unknown opcodes retire as no-ops so the counter stays honest.
                        ctrl.illegal_op = 1'b1;
                        ctrl.retire     = 1'b1;
                        state_d         = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = bus.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = bus.mem_ready;
                state_d        = bus.mem_ready ? StFetch : StMemWr;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
                state_d        = StRWb;
            end
            StRWb: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.retire        = 1'b1;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
                ctrl.retire    = 1'b1;
            end
            StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = StAddiWb;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Outputs are masked combinationally so no strobe leaks while reset is held.
    assign ctrl_out = reset ? ctrl : '0;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.illegal_op    = ctrl_out.illegal_op;
    assign bus.retire        = ctrl_out.retire;
    assign bus.instr_count   = instr_count_q;
    assign bus.state         = reset ? state_q : StFetch;
endmodule
